mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Pipeline boundary between the MEM and WB stages of the five-stage ARM core. Handshakes with a variable-latency data memory (request/ready), freezes upstream stages while an access is outstanding, and registers the writeback record for WB. Also selects the writeback value and keeps a saturating count of memory stall cycles.

## Interface
- STALL_CNT_W, 16, width of the saturating stall counter
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- wb_en  in  1  MEM-stage instruction writes a register
- mem_r_en  in  1  MEM-stage instruction is a load (LDR)
- mem_w_en  in  1  MEM-stage instruction is a store (STR)
- alu_res  in  32  ALU result; memory address for LDR/STR
- val_rm  in  32  store data
- dest  in  4  destination register index
- pc_in  in  32  instruction PC
- mem_rdata  in  32  data memory read data; valid when mem_ready=1
- mem_ready  in  1  data memory completes the current request this cycle
- mem_req  out  1  access request to data memory (combinational)
- mem_we  out  1  write qualifier for mem_req
- mem_addr  out  32  equals alu_res
- mem_wdata  out  32  equals val_rm
- freeze  out  1  hold IF/ID/EXE and EXE/MEM registers this cycle (combinational)
- wb_en_out  out  1  registered writeback enable
- wb_value  out  32  registered writeback value
- wb_dest  out  4  registered destination
- pc_out  out  32  registered PC
- stall_cnt  out  STALL_CNT_W  saturating count of freeze cycles

## Operation
- FSM states: IDLE, WAIT.
- acc = mem_r_en | mem_w_en. A mem_r_en and mem_w_en pair both high is illegal upstream; if it occurs, the load has priority (mem_we=0).
- IDLE, acc=0: mem_req=0, freeze=0; the WB register loads {wb_en, alu_res, dest, pc_in} at the next edge.
- IDLE, acc=1: mem_req=1, mem_we=mem_w_en.
  - mem_ready=1 in the same cycle (zero wait): freeze=0, WB register loads this cycle, state stays IDLE.
  - Otherwise: freeze=1, WB register loads a bubble (wb_en_out=0, other fields hold), next state WAIT.
- WAIT: mem_req=1 held, mem_we held. Upstream inputs are stable because freeze=1.
  - mem_ready=0: freeze=1, bubble.
  - mem_ready=1: freeze=0, WB register loads, next state IDLE.
- wb_value = mem_r_en ? mem_rdata : alu_res, captured at the completing edge.
- A store loads wb_en_out=wb_en, which is normally 0. Stores never alter wb_value semantics.
- stall_cnt increments by 1 on every edge where freeze=1, saturates at all-ones, and never wraps.
- freeze = (acc & ~mem_ready) in IDLE, and ~mem_ready in WAIT.

## Timing
- Reset values: state IDLE, wb_en_out 0, wb_value 0, wb_dest 0, pc_out 0, stall_cnt 0. Combinational outputs follow from IDLE with the inputs present.
- Reset mid-WAIT: the next edge returns to IDLE, mem_req drops, and no writeback occurs for the aborted access.
- Latency:
  - Non-memory op: 1 cycle to WB outputs.
  - Memory op: 1 + N cycles, where N = cycles before mem_ready.
  - A single-cycle freeze costs exactly one bubble in WB.
- Back-to-back memory ops: the second op is presented the cycle after completion and starts in IDLE without a dead cycle.
- mem_ready while mem_req=0 is ignored.
- The WB register never re-issues the previous instruction during a stall. A bubble always has wb_en_out=0.

## Structure
- Shared package: FSM state enum {IDLE, WAIT}; the bubble writeback record constant; the 32-bit word width and the 4-bit register-index width.
- One sub-module is natural: mem_wb_reg (writeback register with load/bubble/reset controls). The FSM, freeze logic and counter stay in the top.

## Test plan
- ALU op (wb_en=1, alu_res=0x0000_0010, dest=3), no access -> next cycle wb_en_out=1, wb_value=0x10, wb_dest=3, freeze never asserted.
- LDR, mem_ready high same cycle, mem_rdata=0xDEAD_BEEF, dest=5 -> freeze=0, next cycle wb_value=0xDEADBEEF, wb_dest=5.
- LDR with mem_ready delayed 3 cycles (rdata=0x1234_5678) -> freeze high 3 cycles, wb_en_out=0 for those 3 edges, then wb_value=0x12345678, stall_cnt=3.
- STR addr=0x40 data=0xAA, ready after 1 cycle -> mem_we=1, mem_addr=0x40, mem_wdata=0xAA held during WAIT, wb_en_out=0 throughout, stall_cnt +1.
- rst asserted during WAIT -> next cycle mem_req=0, freeze=0, all registered outputs 0, and a later mem_ready causes no writeback.
- STALL_CNT_W=2, five stalled cycles -> stall_cnt reads 3 and stays at 3.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared types and widths for the MEM/WB pipeline boundary.
//   - WORD_W / REG_W : data word and register-index widths
//   - state_e        : memory handshake FSM states
//   - wb_rec_t       : writeback record carried into WB
//   - WB_BUBBLE      : reset record; a stall applies only its wb_en bit
package mem_wb_stage_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic              wb_en;
        logic [WORD_W-1:0] value;
        logic [REG_W-1:0]  dest;
        logic [WORD_W-1:0] pc;
    } wb_rec_t;

    localparam wb_rec_t WB_BUBBLE = '{wb_en: 1'b0, value: '0, dest: '0, pc: '0};

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: request/ready bus between the MEM stage and data memory.
//   master (stage) : drives mem_req, mem_we, mem_addr, mem_wdata; samples mem_rdata, mem_ready
//   slave (memory) : the reverse
interface mem_wb_stage_if;

    logic                                 mem_req;
    logic                                 mem_we;
    logic [mem_wb_stage_pkg::WORD_W-1:0]  mem_addr;
    logic [mem_wb_stage_pkg::WORD_W-1:0]  mem_wdata;
    logic [mem_wb_stage_pkg::WORD_W-1:0]  mem_rdata;
    logic                                 mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: writeback pipeline register.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture rec_in at the next edge; otherwise insert a bubble
//   rec_in   : record to capture
//   rec_q    : registered record driving WB
module mem_wb_reg
    import mem_wb_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  wb_rec_t rec_in,
    output wb_rec_t rec_q
);

    wb_rec_t rec_d;

    // A bubble only kills wb_en; the data fields hold so WB never sees a re-issue.
    always_comb begin
        rec_d = rec_q;
        if (load) begin
            rec_d = rec_in;
        end else begin
            rec_d.wb_en = WB_BUBBLE.wb_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_q <= WB_BUBBLE;
        end else begin
            rec_q <= rec_d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB boundary with a variable-latency data memory handshake.
//   clk, rst           : clock, synchronous active-high reset
//   wb_en, mem_r_en,
//   mem_w_en, alu_res,
//   val_rm, dest, pc_in: MEM-stage instruction
//   mem_if (master)    : data memory request/ready bus
//   freeze             : combinational hold for upstream stages
//   wb_en_out, wb_value,
//   wb_dest, pc_out    : registered writeback record
//   stall_cnt          : saturating count of freeze cycles
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [WORD_W-1:0]      alu_res,
    input  logic [WORD_W-1:0]      val_rm,
    input  logic [REG_W-1:0]       dest,
    input  logic [WORD_W-1:0]      pc_in,
    mem_wb_stage_if.master         mem_if,
    output logic                   freeze,
    output logic                   wb_en_out,
    output logic [WORD_W-1:0]      wb_value,
    output logic [REG_W-1:0]       wb_dest,
    output logic [WORD_W-1:0]      pc_out,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

    state_e                 state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   acc;
    logic                   mem_req_c;
    logic                   load_c;
    wb_rec_t                rec_in;
    wb_rec_t                rec_q;

    assign acc = mem_r_en | mem_w_en;

    // Handshake FSM: WAIT holds the request until memory signals ready.
    always_comb begin
        state_d   = state_q;
        mem_req_c = 1'b0;
        freeze    = 1'b0;
        load_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    mem_req_c = 1'b1;
                    if (mem_if.mem_ready) begin
                        load_c = 1'b1;
                    end else begin
                        freeze  = 1'b1;
                        state_d = WAIT;
                    end
                end else begin
                    load_c = 1'b1;
                end
            end
            WAIT: begin
                mem_req_c = 1'b1;
                if (mem_if.mem_ready) begin
                    load_c  = 1'b1;
                    state_d = IDLE;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load wins over store if both are flagged.
    assign mem_if.mem_req   = mem_req_c;
    assign mem_if.mem_we    = mem_req_c & mem_w_en & ~mem_r_en;
    assign mem_if.mem_addr  = alu_res;
    assign mem_if.mem_wdata = val_rm;

    always_comb begin
        rec_in       = WB_BUBBLE;
        rec_in.wb_en = wb_en;
        rec_in.value = mem_r_en ? mem_if.mem_rdata : alu_res;
        rec_in.dest  = dest;
        rec_in.pc    = pc_in;
    end

    // Saturating stall counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (freeze && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    mem_wb_reg u_wb_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (load_c),
        .rec_in (rec_in),
        .rec_q  (rec_q)
    );

    assign wb_en_out = rec_q.wb_en;
    assign wb_value  = rec_q.value;
    assign wb_dest   = rec_q.dest;
    assign pc_out    = rec_q.pc;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: transaction-level check of mem_wb_stage; a second instance
// with a 2-bit stall counter shares the stimulus to exercise saturation.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_res, val_rm, pc_in, rdata;
    logic [3:0]  dest;
    logic        ready;

    logic        freeze_a, wb_en_out_a, freeze_b, wb_en_out_b;
    logic [31:0] wb_value_a, pc_out_a, wb_value_b, pc_out_b;
    logic [3:0]  wb_dest_a, wb_dest_b;
    logic [15:0] stall_cnt_a;
    logic [1:0]  stall_cnt_b;

    mem_wb_stage_if mem_if_a ();
    mem_wb_stage_if mem_if_b ();

    assign mem_if_a.mem_rdata = rdata;
    assign mem_if_a.mem_ready = ready;
    assign mem_if_b.mem_rdata = rdata;
    assign mem_if_b.mem_ready = ready;

    always #5 clk = ~clk;

    mem_wb_stage #(.STALL_CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_res(alu_res), .val_rm(val_rm), .dest(dest), .pc_in(pc_in), .mem_if(mem_if_a),
        .freeze(freeze_a), .wb_en_out(wb_en_out_a), .wb_value(wb_value_a),
        .wb_dest(wb_dest_a), .pc_out(pc_out_a), .stall_cnt(stall_cnt_a)
    );

    mem_wb_stage #(.STALL_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_res(alu_res), .val_rm(val_rm), .dest(dest), .pc_in(pc_in), .mem_if(mem_if_b),
        .freeze(freeze_b), .wb_en_out(wb_en_out_b), .wb_value(wb_value_b),
        .wb_dest(wb_dest_b), .pc_out(pc_out_b), .stall_cnt(stall_cnt_b)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned total_stall;
    logic        exp_en;
    logic [31:0] exp_val, exp_pc;
    logic [3:0]  exp_dest;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs();
        int unsigned sat_a, sat_b;
        sat_a = (total_stall > 65535) ? 65535 : total_stall;
        sat_b = (total_stall > 3) ? 3 : total_stall;
        check_eq("wb_en_out", 64'(wb_en_out_a), 64'(exp_en));
        check_eq("wb_value",  64'(wb_value_a),  64'(exp_val));
        check_eq("wb_dest",   64'(wb_dest_a),   64'(exp_dest));
        check_eq("pc_out",    64'(pc_out_a),    64'(exp_pc));
        check_eq("wb_en_out_b", 64'(wb_en_out_b), 64'(exp_en));
        check_eq("wb_value_b",  64'(wb_value_b),  64'(exp_val));
        check_eq("stall_cnt",   64'(stall_cnt_a), 64'(sat_a));
        check_eq("stall_cnt_b", 64'(stall_cnt_b), 64'(sat_b));
    endtask

    // kind: 0 ALU, 1 LDR, 2 STR, 3 illegal LDR+STR; n = cycles before mem_ready.
    task automatic run_op(input int kind, input int n, input logic en, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] dst, input logic [31:0] pc,
                          input logic [31:0] rd);
        logic r, w;
        int   waits;
        r = (kind == 1) || (kind == 3);
        w = (kind == 2) || (kind == 3);
        waits = (r | w) ? n : 0;
        mem_r_en = r; mem_w_en = w; wb_en = en;
        alu_res = a; val_rm = d; dest = dst; pc_in = pc;
        for (int c = 0; c <= waits; c++) begin
            if (r | w) begin
                ready = (c == waits);
                rdata = (c == waits) ? rd : $urandom;
            end else begin
                ready = 1'($urandom_range(0, 1));
                rdata = $urandom;
            end
            @(negedge clk);
            check_eq("mem_req",  64'(mem_if_a.mem_req), 64'(r | w));
            check_eq("freeze",   64'(freeze_a), 64'(c < waits));
            check_eq("freeze_b", 64'(freeze_b), 64'(c < waits));
            if (r | w) begin
                check_eq("mem_we",    64'(mem_if_a.mem_we),    64'(w & ~r));
                check_eq("mem_addr",  64'(mem_if_a.mem_addr),  64'(a));
                check_eq("mem_wdata", 64'(mem_if_a.mem_wdata), 64'(d));
            end
            @(posedge clk);
            #1;
            if (c < waits) begin
                total_stall++;
                exp_en = 1'b0;
            end else begin
                exp_en   = en;
                exp_val  = r ? rd : a;
                exp_dest = dst;
                exp_pc   = pc;
            end
            check_regs();
        end
    endtask

    task automatic clear_model();
        total_stall = 0;
        exp_en = 1'b0; exp_val = '0; exp_dest = '0; exp_pc = '0;
    endtask

    initial begin
        int kind, n;
        rst = 1'b1; wb_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        alu_res = '0; val_rm = '0; dest = '0; pc_in = '0; rdata = '0; ready = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        check_eq("reset_mem_req", 64'(mem_if_a.mem_req), 64'(0));
        rst = 1'b0;

        // Directed cases
        run_op(0, 0, 1'b1, 32'h0000_0010, 32'h0,  4'd3, 32'h100, 32'h0);
        run_op(1, 0, 1'b1, 32'h0000_0080, 32'h0,  4'd5, 32'h104, 32'hDEAD_BEEF);
        run_op(1, 3, 1'b1, 32'h0000_0084, 32'h0,  4'd6, 32'h108, 32'h1234_5678);
        check_eq("stall_after_ldr3", 64'(stall_cnt_a), 64'(3));
        run_op(2, 1, 1'b0, 32'h0000_0040, 32'hAA, 4'd7, 32'h10C, 32'h5555_5555);
        run_op(1, 0, 1'b1, 32'h0000_0044, 32'h0,  4'd8, 32'h110, 32'hCAFE_F00D);
        run_op(1, 5, 1'b1, 32'h0000_0048, 32'h0,  4'd9, 32'h114, 32'h0BAD_F00D);
        check_eq("stall_b_saturated", 64'(stall_cnt_b), 64'(3));
        run_op(3, 2, 1'b1, 32'h0000_004C, 32'h77, 4'd2, 32'h118, 32'h7777_0000);

        // Reset while waiting on memory
        mem_r_en = 1'b1; mem_w_en = 1'b0; wb_en = 1'b1; alu_res = 32'h200;
        dest = 4'd4; pc_in = 32'h120; ready = 1'b0;
        @(posedge clk);
        #1;
        total_stall++;
        exp_en = 1'b0;
        check_regs();
        rst = 1'b1; mem_r_en = 1'b0; wb_en = 1'b0; alu_res = '0; dest = '0; pc_in = '0;
        @(posedge clk);
        #1;
        clear_model();
        check_regs();
        rst = 1'b0; ready = 1'b1; rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check_eq("rst_mem_req", 64'(mem_if_a.mem_req), 64'(0));
        check_eq("rst_freeze",  64'(freeze_a), 64'(0));
        @(posedge clk);
        #1;
        check_regs();

        // Randomized stream
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3)      kind = 0;
            else if (kind <= 6) kind = 1;
            else if (kind <= 8) kind = 2;
            else                kind = 3;
            n = $urandom_range(0, 4);
            run_op(kind, n, 1'($urandom_range(0, 1)), $urandom, $urandom,
                   4'($urandom_range(0, 15)), $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
